ssp_arbiter: RTL and testbench

- Shares one SSP (APB-style PSEL/PWRITE/PWDATA/PRDATA port, 4-deep TX/RX FIFOs) between NREQ byte requesters.
- Round-robin grants TX writes into the SSP TX FIFO, and drains the RX FIFO when it fills.
- Tags each received byte with the requester whose transmitted byte produced it, using an internal tag FIFO.
- Sits between the requester clients and the ssp block, on PCLK.

---
 rtl/ssp_arb_pkg.sv | 38 +++
 rtl/ssp_tag_fifo.sv | 55 +++++
 rtl/ssp_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ssp_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_arb_pkg.sv
// Shared types and helpers for the SSP arbiter: FSM state encoding, the SSP FIFO
// depth, and the round-robin winner search.
package ssp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR     = 2'd1,
    RD     = 2'd2,
    RD_CAP = 2'd3
  } state_e;

  localparam int SSP_FIFO_DEPTH = 4;

  // Largest supported requester count and the index width that covers it.
  localparam int MAX_REQ = 8;
  localparam int PTR_W   = 3;

  // The request vector is zero-padded to MAX_REQ bits by the caller. Because
  // ptr < NREQ and the padding bits are zero, a search that wraps modulo MAX_REQ
  // visits the live requesters in the same order as a search modulo NREQ.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/ssp_tag_fifo.sv
// Circular FIFO of requester IDs; one entry per byte written to the SSP TX FIFO.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module ssp_tag_fifo #(
  parameter int TAG_DEPTH = 4,
  parameter int TAGW      = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [TAGW-1:0] din,
  output logic [TAGW-1:0] dout,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(TAG_DEPTH);

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic [TAGW-1:0] mem_q [TAG_DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; resetting the pointers is enough to make every
  // entry unreachable, and it keeps the array plain RAM-style storage.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ssp_arbiter.sv
// Shares one SSP port between NREQ byte requesters: round-robin TX writes, RX
// drains with priority, received bytes tagged with their requester. Optional
// sticky grant under SSP_ARB_LOCK_EN (adds the LOCK input).
module ssp_arbiter
  import ssp_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int TAG_DEPTH = SSP_FIFO_DEPTH,
  localparam int TAGW      = $clog2(NREQ)
) (
  input  logic              PCLK,
  input  logic              CLEAR,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] REQ_DATA,
  output logic [NREQ-1:0]   GNT,
  input  logic              SSPTXINTR,
  input  logic              SSPRXINTR,
  input  logic [7:0]        PRDATA,
  output logic              PSEL,
  output logic              PWRITE,
  output logic [7:0]        PWDATA,
  output logic              RX_VALID,
  output logic [7:0]        RX_DATA,
  output logic [TAGW-1:0]   RX_TAG,
`ifdef SSP_ARB_LOCK_EN
  input  logic [NREQ-1:0]   LOCK,
`endif
  output logic              RX_ORPHAN
);

  state_e          state_q, state_d;
  logic [TAGW-1:0] ptr_q, ptr_d;
  logic [TAGW-1:0] win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            psel_q, psel_d;
  logic            pwrite_q, pwrite_d;
  logic [7:0]      pwdata_q, pwdata_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic [TAGW-1:0] rx_tag_q, rx_tag_d;
  logic            rx_orphan_q, rx_orphan_d;

  logic            tag_push, tag_pop, tag_full, tag_empty;
  logic [TAGW-1:0] tag_dout;
  logic [TAGW-1:0] rr_win, pick;
  logic [7:0]      req_bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = REQ_DATA[8*i +: 8];
  end

  // win_q doubles as "last winner": a locked winner that is still requesting
  // jumps the round-robin order; ptr_q still points past it for when it lets go.
  always_comb begin
    rr_win = TAGW'(rr_pick(MAX_REQ'(REQ), PTR_W'(ptr_q)));
`ifdef SSP_ARB_LOCK_EN
    pick = (LOCK[win_q] && REQ[win_q]) ? win_q : rr_win;
`else
    pick = rr_win;
`endif
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = '0;
    psel_d      = 1'b0;
    pwrite_d    = 1'b0;
    pwdata_d    = pwdata_q;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_tag_d    = rx_tag_q;
    rx_orphan_d = 1'b0;
    tag_push    = 1'b0;
    tag_pop     = 1'b0;

    // Outputs are computed one state ahead so they register in step with state_q.
    case (state_q)
      IDLE: begin
        if (SSPRXINTR) begin
          state_d = RD;
          psel_d  = 1'b1;
        end else if (|REQ && !SSPTXINTR && !tag_full) begin
          state_d     = WR;
          win_d       = pick;
          gnt_d[pick] = 1'b1;
          psel_d      = 1'b1;
          pwrite_d    = 1'b1;
          pwdata_d    = req_bytes[pick];
        end
      end
      WR: begin
        tag_push = 1'b1;
        ptr_d    = (win_q == TAGW'(NREQ-1)) ? '0 : win_q + TAGW'(1);
        state_d  = IDLE;
      end
      RD: begin
        state_d     = RD_CAP;
        rx_valid_d  = 1'b1;
        rx_data_d   = PRDATA;
        tag_pop     = !tag_empty;
        rx_tag_d    = tag_empty ? '0 : tag_dout;
        rx_orphan_d = tag_empty;
      end
      RD_CAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge CLEAR) begin
    if (CLEAR) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      psel_q      <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_tag_q    <= '0;
      rx_orphan_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      psel_q      <= psel_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_tag_q    <= rx_tag_d;
      rx_orphan_q <= rx_orphan_d;
    end
  end

  ssp_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH),
    .TAGW      (TAGW)
  ) u_tag_fifo (
    .clk   (PCLK),
    .rst   (CLEAR),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (win_q),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign GNT       = gnt_q;
  assign PSEL      = psel_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign RX_VALID  = rx_valid_q;
  assign RX_DATA   = rx_data_q;
  assign RX_TAG    = rx_tag_q;
  assign RX_ORPHAN = rx_orphan_q;

endmodule

// File: tb/tb_ssp_arbiter.sv
// Directed testbench for ssp_arbiter (NREQ=4); the LOCK scenario runs only when
// SSP_ARB_LOCK_EN is defined.
module tb_ssp_arbiter;

  logic        PCLK;
  logic        CLEAR;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [3:0]  GNT;
  logic        SSPTXINTR;
  logic        SSPRXINTR;
  logic [7:0]  PRDATA;
  logic        PSEL;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic [1:0]  RX_TAG;
  logic        RX_ORPHAN;
`ifdef SSP_ARB_LOCK_EN
  logic [3:0]  LOCK;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  ssp_arbiter #(.NREQ(4), .TAG_DEPTH(4)) dut (
    .PCLK      (PCLK),
    .CLEAR     (CLEAR),
    .REQ       (REQ),
    .REQ_DATA  (REQ_DATA),
    .GNT       (GNT),
    .SSPTXINTR (SSPTXINTR),
    .SSPRXINTR (SSPRXINTR),
    .PRDATA    (PRDATA),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .RX_VALID  (RX_VALID),
    .RX_DATA   (RX_DATA),
    .RX_TAG    (RX_TAG),
`ifdef SSP_ARB_LOCK_EN
    .LOCK      (LOCK),
`endif
    .RX_ORPHAN (RX_ORPHAN)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] all_outs();
    return {GNT, PSEL, PWRITE, PWDATA, RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN};
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Leaves the DUT in IDLE with CLEAR released 1 time unit after a posedge.
  task automatic reset_dut();
    CLEAR     = 1'b1;
    REQ       = '0;
    REQ_DATA  = '0;
    SSPTXINTR = 1'b0;
    SSPRXINTR = 1'b0;
    PRDATA    = '0;
`ifdef SSP_ARB_LOCK_EN
    LOCK      = '0;
`endif
    tick();
    tick();
    CLEAR = 1'b0;
  endtask

  task automatic test_reset();
    CLEAR     = 1'b1;
    REQ       = 4'hF;
    REQ_DATA  = 32'h44332211;
    SSPTXINTR = 1'b0;
    SSPRXINTR = 1'b0;
    PRDATA    = 8'h00;
`ifdef SSP_ARB_LOCK_EN
    LOCK      = '0;
`endif
    tick();
    tick();
    total_cnt++;
    if (all_outs() !== 26'd0) $display("FAIL reset_outputs: got %h want 0", all_outs());
    else pass_cnt++;
    CLEAR = 1'b0;
    total_cnt++;
    if ({PSEL, GNT} !== 5'b0) $display("FAIL reset_release_cycle1: psel/gnt got %b want 00000", {PSEL, GNT});
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({PSEL, PWRITE, GNT, PWDATA} !== {1'b1, 1'b1, 4'b0001, 8'h11})
      $display("FAIL reset_first_gnt: psel/pwrite/gnt/pwdata got %b %b %b %h want 1 1 0001 11",
               PSEL, PWRITE, GNT, PWDATA);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [7:0] exp_data;
    reset_dut();
    REQ      = 4'hF;
    REQ_DATA = 32'h44332211;
    for (int k = 0; k < 4; k++) begin
      exp_gnt  = 4'b0001 << k;
      exp_data = 8'((k + 1) * 17);
      tick();
      total_cnt++;
      if ({GNT, PWDATA, PSEL, PWRITE} !== {exp_gnt, exp_data, 2'b11})
        $display("FAIL rr_grant%0d: gnt/pwdata/psel/pwrite got %b %h %b%b want %b %h 11",
                 k, GNT, PWDATA, PSEL, PWRITE, exp_gnt, exp_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({GNT, PSEL, PWRITE} !== 6'b0)
        $display("FAIL rr_gap%0d: gnt/psel/pwrite got %b %b%b want 0000 00", k, GNT, PSEL, PWRITE);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    SSPTXINTR = 1'b1;
    REQ       = 4'b0100;
    REQ_DATA  = 32'h00770000;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if ({PSEL, GNT} !== 5'b0) $display("FAIL bp_stall%0d: psel/gnt got %b want 00000", k, {PSEL, GNT});
      else pass_cnt++;
    end
    SSPTXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({GNT, PWDATA, PSEL, PWRITE} !== {4'b0100, 8'h77, 2'b11})
      $display("FAIL bp_release: gnt/pwdata/psel/pwrite got %b %h %b%b want 0100 77 11",
               GNT, PWDATA, PSEL, PWRITE);
    else pass_cnt++;
    REQ = 4'b0000;
    tick();
    total_cnt++;
    if ({GNT, PSEL, PWRITE, PWDATA} !== {6'b0, 8'h77})
      $display("FAIL pwdata_hold: gnt/psel/pwrite/pwdata got %b %b%b %h want 0000 00 77",
               GNT, PSEL, PWRITE, PWDATA);
    else pass_cnt++;
  endtask

  task automatic test_tagging();
    reset_dut();
    REQ      = 4'b0100;
    REQ_DATA = 32'h00A50000;
    tick();
    total_cnt++;
    if ({GNT, PWDATA} !== {4'b0100, 8'hA5}) $display("FAIL tag_gnt2: gnt/pwdata got %b %h want 0100 a5", GNT, PWDATA);
    else pass_cnt++;
    REQ      = 4'b0001;
    REQ_DATA = 32'h0000003C;
    tick();
    tick();
    total_cnt++;
    if ({GNT, PWDATA} !== {4'b0001, 8'h3C}) $display("FAIL tag_gnt0: gnt/pwdata got %b %h want 0001 3c", GNT, PWDATA);
    else pass_cnt++;
    REQ = 4'b0000;
    tick();
    // First read: tag of requester 2
    SSPRXINTR = 1'b1;
    tick();
    total_cnt++;
    if ({PSEL, PWRITE, GNT} !== {2'b10, 4'b0000}) $display("FAIL tag_rd_phase: psel/pwrite/gnt got %b%b %b want 10 0000", PSEL, PWRITE, GNT);
    else pass_cnt++;
    PRDATA    = 8'h11;
    SSPRXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN, PSEL} !== {1'b1, 8'h11, 2'd2, 1'b0, 1'b0})
      $display("FAIL tag_rx1: valid/data/tag/orphan/psel got %b %h %0d %b %b want 1 11 2 0 0",
               RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN, PSEL);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RX_VALID !== 1'b0) $display("FAIL tag_rx_pulse: rx_valid got %b want 0", RX_VALID);
    else pass_cnt++;
    // Second read: tag of requester 0
    SSPRXINTR = 1'b1;
    tick();
    PRDATA    = 8'h22;
    SSPRXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN} !== {1'b1, 8'h22, 2'd0, 1'b0})
      $display("FAIL tag_rx2: valid/data/tag/orphan got %b %h %0d %b want 1 22 0 0",
               RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN);
    else pass_cnt++;
    tick();
    // Third read: tag FIFO is empty
    SSPRXINTR = 1'b1;
    tick();
    PRDATA    = 8'h33;
    SSPRXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN} !== {1'b1, 8'h33, 2'd0, 1'b1})
      $display("FAIL tag_orphan: valid/data/tag/orphan got %b %h %0d %b want 1 33 0 1",
               RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_tag_full_priority();
    reset_dut();
    REQ      = 4'hF;
    REQ_DATA = 32'h44332211;
    for (int k = 0; k < 8; k++) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if ({PSEL, GNT} !== 5'b0) $display("FAIL full_stall%0d: psel/gnt got %b want 00000", k, {PSEL, GNT});
      else pass_cnt++;
    end
    SSPRXINTR = 1'b1;
    tick();
    total_cnt++;
    if ({PSEL, PWRITE, GNT} !== {2'b10, 4'b0000})
      $display("FAIL prio_rd_first: psel/pwrite/gnt got %b%b %b want 10 0000", PSEL, PWRITE, GNT);
    else pass_cnt++;
    PRDATA    = 8'h5A;
    SSPRXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN, PSEL} !== {1'b1, 8'h5A, 2'd0, 1'b0, 1'b0})
      $display("FAIL prio_rd_cap: valid/data/tag/orphan/psel got %b %h %0d %b %b want 1 5a 0 0 0",
               RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN, PSEL);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({RX_VALID, PSEL, GNT} !== 6'b0) $display("FAIL prio_idle: valid/psel/gnt got %b %b %b want 0 0 0000", RX_VALID, PSEL, GNT);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({GNT, PWDATA, PSEL, PWRITE} !== {4'b0001, 8'h11, 2'b11})
      $display("FAIL prio_wr_after: gnt/pwdata/psel/pwrite got %b %h %b%b want 0001 11 11",
               GNT, PWDATA, PSEL, PWRITE);
    else pass_cnt++;
    REQ = 4'b0000;
    tick();
  endtask

  task automatic test_mid_reset();
    reset_dut();
    REQ      = 4'b0001;
    REQ_DATA = 32'h000000E1;
    tick();
    REQ = 4'b0000;
    tick();
    SSPRXINTR = 1'b1;
    tick();
    total_cnt++;
    if ({PSEL, PWRITE, PWDATA} !== {2'b10, 8'hE1})
      $display("FAIL midrst_rd: psel/pwrite/pwdata got %b%b %h want 10 e1", PSEL, PWRITE, PWDATA);
    else pass_cnt++;
    #2;
    CLEAR = 1'b1;
    #1;
    total_cnt++;
    if (all_outs() !== 26'd0) $display("FAIL midrst_async: outputs got %h want 0", all_outs());
    else pass_cnt++;
    SSPRXINTR = 1'b0;
    PRDATA    = 8'hEE;
    tick();
    total_cnt++;
    if (all_outs() !== 26'd0) $display("FAIL midrst_no_rxvalid: outputs got %h want 0", all_outs());
    else pass_cnt++;
    CLEAR     = 1'b0;
    SSPRXINTR = 1'b1;
    tick();
    PRDATA    = 8'h9C;
    SSPRXINTR = 1'b0;
    tick();
    total_cnt++;
    if ({RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN} !== {1'b1, 8'h9C, 2'd0, 1'b1})
      $display("FAIL midrst_tag_empty: valid/data/tag/orphan got %b %h %0d %b want 1 9c 0 1",
               RX_VALID, RX_DATA, RX_TAG, RX_ORPHAN);
    else pass_cnt++;
    tick();
  endtask

`ifdef SSP_ARB_LOCK_EN
  task automatic test_lock();
    reset_dut();
    REQ      = 4'b0010;
    REQ_DATA = 32'h0000B200;
    tick();
    total_cnt++;
    if (GNT !== 4'b0010) $display("FAIL lock_first: gnt got %b want 0010", GNT);
    else pass_cnt++;
    REQ      = 4'b0011;
    REQ_DATA = 32'h0000B2A0;
    LOCK     = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      tick();
      tick();
      total_cnt++;
      if ({GNT, PWDATA} !== {4'b0010, 8'hB2}) $display("FAIL lock_regrant%0d: gnt/pwdata got %b %h want 0010 b2", k, GNT, PWDATA);
      else pass_cnt++;
    end
    LOCK = 4'b0000;
    tick();
    tick();
    total_cnt++;
    if ({GNT, PWDATA} !== {4'b0001, 8'hA0}) $display("FAIL lock_release: gnt/pwdata got %b %h want 0001 a0", GNT, PWDATA);
    else pass_cnt++;
    REQ = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_tagging();
    test_tag_full_priority();
    test_mid_reset();
`ifdef SSP_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
